// File: rtl/serial_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_framer
//  Purpose  : Serial frame transmitter. A start request latches a parallel
//             word. The block then shifts out a fixed start sequence, the
//             data word MSB-first and an optional parity bit on a single
//             registered line, and finally pulses done. It supports a
//             synchronous abort and back-to-back frames.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-high reset
//             start    - frame request (accepted in IDLE/DONE when abort=0)
//             abort    - synchronous cancel of a frame in flight
//             tx_data  - word to send, latched when start is accepted
//             s_data   - serial line (registered)
//             busy     - high while frame bits are on the line (registered)
//             done     - one-cycle pulse after a completed frame (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx_framer #(
   parameter int               DATA_W     = 55,
   parameter int               SEQ_W      = 6,
   parameter logic [SEQ_W-1:0] START_SEQ  = 6'b011111,
   parameter bit               PARITY_EN  = 1'b0,
   parameter bit               PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] tx_data,
   output logic              s_data,
   output logic              busy,
   output logic              done
);

   localparam int MAX_W = (SEQ_W > DATA_W) ? SEQ_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   localparam logic [CNT_W-1:0] C_SEQ_LEN  = CNT_W'(SEQ_W);
   localparam logic [CNT_W-1:0] C_DATA_LEN = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEQ  = 3'd1,
      S_DATA = 3'd2,
      S_PAR  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   logic [SEQ_W-1:0]    r_seq;
   logic [DATA_W-1:0]   r_shift;
   logic                r_par;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_accept;
   logic                w_parity;

   assign w_accept = start & ~abort;
   // Parity is taken from the word being latched, so later tx_data changes
   // cannot disturb it.
   assign w_parity = PARITY_ODD ? ~^tx_data : ^tx_data;

   // The state names the bit class currently on the line. The outputs are
   // produced on the same edge that selects the next bit, so every output is
   // a flop. r_cnt holds the number of bits of the current class still on
   // the line, including the one being driven now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_seq   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_cnt   <= '0;
         s_data  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               s_data <= 1'b0;
               busy   <= 1'b0;
               if (w_accept) begin
                  // The first start-sequence bit goes out right away. The
                  // rest of the pattern is queued in r_seq.
                  r_state <= S_SEQ;
                  r_cnt   <= C_SEQ_LEN;
                  r_seq   <= START_SEQ << 1;
                  r_shift <= tx_data;
                  r_par   <= w_parity;
                  s_data  <= START_SEQ[SEQ_W-1];
                  busy    <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end

            S_SEQ: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  s_data  <= 1'b0;
                  busy    <= 1'b0;
               end else if (r_cnt == C_ONE) begin
                  r_state <= S_DATA;
                  r_cnt   <= C_DATA_LEN;
                  s_data  <= r_shift[DATA_W-1];
                  r_shift <= r_shift << 1;
               end else begin
                  r_cnt   <= r_cnt - C_ONE;
                  s_data  <= r_seq[SEQ_W-1];
                  r_seq   <= r_seq << 1;
               end
            end

            S_DATA: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  s_data  <= 1'b0;
                  busy    <= 1'b0;
               end else if (r_cnt == C_ONE) begin
                  r_cnt <= C_ONE;
                  if (PARITY_EN) begin
                     r_state <= S_PAR;
                     s_data  <= r_par;
                  end else begin
                     r_state <= S_DONE;
                     s_data  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end else begin
                  r_cnt   <= r_cnt - C_ONE;
                  s_data  <= r_shift[DATA_W-1];
                  r_shift <= r_shift << 1;
               end
            end

            S_PAR: begin
               s_data <= 1'b0;
               busy   <= 1'b0;
               r_cnt  <= C_ONE;
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               s_data  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_framer
//  Purpose  : Self-checking bench for serial_tx_framer. It runs three
//             instances: the default configuration, an 8-bit word with even
//             parity, and an 8-bit word with odd parity. A frame-level
//             reference model is checked against all three every cycle, and
//             literal expected frames are compared as well.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_framer;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [54:0] tx55  = '0;
   logic [7:0]  tx8   = '0;
   logic [2:0]  sd;
   logic [2:0]  bz;
   logic [2:0]  dn;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_tx_framer u_dflt (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .tx_data (tx55),
      .s_data  (sd[0]),
      .busy    (bz[0]),
      .done    (dn[0])
   );

   serial_tx_framer #(
      .DATA_W(8), .SEQ_W(6), .START_SEQ(6'b011111), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
   ) u_even (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .tx_data (tx8),
      .s_data  (sd[1]),
      .busy    (bz[1]),
      .done    (dn[1])
   );

   serial_tx_framer #(
      .DATA_W(8), .SEQ_W(6), .START_SEQ(6'b011111), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
   ) u_odd (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .tx_data (tx8),
      .s_data  (sd[2]),
      .busy    (bz[2]),
      .done    (dn[2])
   );

   // ------------------------------------------------------------------------
   // Reference model. It works at frame level: on accept, the complete bit
   // list of the frame is built. The model then tracks the edges since
   // accept. phase 0 = idle, 1 = frame bit m_k on the line, 2 = done cycle.
   // ------------------------------------------------------------------------
   int          m_phase [3] = '{0, 0, 0};
   int          m_k     [3] = '{0, 0, 0};
   int          m_len   [3] = '{0, 0, 0};
   logic [79:0] m_frame [3];

   function automatic void load_frame(input int i);
      logic [54:0] d;
      logic [5:0]  seq;
      int          dw;
      int          n;
      int          ones;
      seq  = 6'b011111;
      d    = (i == 0) ? tx55 : {47'b0, tx8};
      dw   = (i == 0) ? 55 : 8;
      n    = 0;
      ones = 0;
      m_frame[i] = '0;
      for (int b = 5; b >= 0; b--) begin
         m_frame[i][n] = seq[b];
         n++;
      end
      for (int b = dw - 1; b >= 0; b--) begin
         m_frame[i][n] = d[b];
         if (d[b]) ones++;
         n++;
      end
      if (i != 0) begin
         m_frame[i][n] = ((ones % 2) == 1) != (i == 2);
         n++;
      end
      m_len[i] = n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) m_phase[i] = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (m_phase[i] == 1) begin
               if (abort)                      m_phase[i] = 0;
               else if (m_k[i] == m_len[i] - 1) m_phase[i] = 2;
               else                            m_k[i]++;
            end else if (start && !abort) begin
               load_frame(i);
               m_k[i]     = 0;
               m_phase[i] = 1;
            end else begin
               m_phase[i] = 0;
            end
         end
      end
   end

   function automatic logic [2:0] expv(input int i);
      if (m_phase[i] == 1) return {m_frame[i][m_k[i]], 2'b10};
      if (m_phase[i] == 2) return 3'b001;
      return 3'b000;
   endfunction

   int cyc = 0;
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
         logic [2:0] e;
         logic [2:0] a;
         e = expv(i);
         a = {sd[i], bz[i], dn[i]};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL model_cmp dut%0d cycle %0d: s_data,busy,done actual %b required %b",
                     i, cyc, a, e);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_phase[0] != 0 || m_phase[1] != 0 || m_phase[2] != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
      end
   endtask

   // Sends one 8-bit frame and captures 15 line bits from both parity
   // instances. It also counts done pulses of the even instance over 20 cycles.
   task automatic send8(input logic [7:0] d, output logic [14:0] c1,
                        output logic [14:0] c2, output int dcnt);
      tx8   = d;
      start = 1'b1;
      c1    = '0;
      c2    = '0;
      dcnt  = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (j < 15) begin
            c1[14-j] = sd[1];
            c2[14-j] = sd[2];
         end
         if (dn[1]) dcnt++;
      end
   endtask

   logic [60:0] cap0;
   logic [14:0] cap1, cap2;
   logic [30:0] capb;
   int          busy_cnt, done_cnt, done_at;

   initial begin
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({sd, bz, dn}), 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // Default 61-bit frame, with an 8-bit A5 frame on the parity instances.
      tx55 = 55'h1;
      tx8  = 8'hA5;
      start = 1'b1;
      cap0 = '0; cap1 = '0; cap2 = '0;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int j = 0; j < 64; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (j < 61) cap0[60-j] = sd[0];
         if (j < 15) begin
            cap1[14-j] = sd[1];
            cap2[14-j] = sd[2];
         end
         if (bz[0]) busy_cnt++;
         if (dn[0]) begin
            done_cnt++;
            done_at = j;
         end
      end
      chk("dflt_frame", 64'(cap0), 64'({6'b011111, 54'b0, 1'b1}));
      chk("dflt_busy_cycles", 64'(busy_cnt), 64'd61);
      chk("dflt_done_count", 64'(done_cnt), 64'd1);
      chk("dflt_done_cycle", 64'(done_at), 64'd61);
      chk("even_A5_frame", 64'(cap1), 64'(15'b011111_10100101_0));
      chk("odd_A5_frame", 64'(cap2), 64'(15'b011111_10100101_1));

      // Back-to-back: start held high through DONE, frames FF then 00.
      wait_idle();
      tx8   = 8'hFF;
      start = 1'b1;
      capb  = '0;
      done_cnt = 0;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         if (j == 0)  tx8 = 8'h00;
         if (j == 16) start = 1'b0;
         if (j < 31) capb[30-j] = sd[1];
         if (dn[1]) done_cnt++;
      end
      chk("b2b_line", 64'(capb),
          64'({15'b011111_11111111_0, 1'b0, 15'b011111_00000000_0}));
      chk("b2b_done_count", 64'(done_cnt), 64'd2);

      // tx_data changes after accept, and a stray start pulse mid-frame.
      wait_idle();
      tx8   = 8'h3C;
      start = 1'b1;
      cap1  = '0;
      done_cnt = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 0) begin
            start = 1'b0;
            tx8   = 8'hC3;
         end
         if (j == 5) start = 1'b1;
         if (j == 6) start = 1'b0;
         if (j < 15) cap1[14-j] = sd[1];
         if (dn[1]) done_cnt++;
      end
      chk("latched_word_frame", 64'(cap1), 64'(15'b011111_00111100_0));
      chk("latched_word_done", 64'(done_cnt), 64'd1);

      // Abort sampled at edge E0+9.
      wait_idle();
      tx8   = 8'hA5;
      start = 1'b1;
      done_cnt = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
         if (j == 8) begin
            chk("busy_before_abort", 64'(bz[1]), 64'd1);
            abort = 1'b1;
         end
         if (j == 9) begin
            chk("abort_line_busy", 64'({sd[1], bz[1], sd[2], bz[2]}), 64'h0);
            abort = 1'b0;
         end
         if (dn[1]) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);

      // In IDLE, abort blocks start.
      wait_idle();
      start = 1'b1;
      abort = 1'b1;
      busy_cnt = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (j == 0) begin
            start = 1'b0;
            abort = 1'b0;
         end
         if (bz != 3'b000) busy_cnt++;
      end
      chk("abort_blocks_start", 64'(busy_cnt), 64'd0);

      send8(8'hA5, cap1, cap2, done_cnt);
      chk("post_abort_frame", 64'(cap1), 64'(15'b011111_10100101_0));
      chk("post_abort_done", 64'(done_cnt), 64'd1);

      // Asynchronous reset in the middle of the data bits.
      wait_idle();
      tx8   = 8'hA5;
      start = 1'b1;
      done_cnt = 0;
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         if (j == 0) start = 1'b0;
      end
      chk("busy_before_reset", 64'(bz[1]), 64'd1);
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", 64'({sd, bz, dn}), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (dn != 3'b000) done_cnt++;
      end
      chk("reset_no_done", 64'(done_cnt), 64'd0);

      send8(8'h5A, cap1, cap2, done_cnt);
      chk("post_reset_even", 64'(cap1), 64'(15'b011111_01011010_0));
      chk("post_reset_odd", 64'(cap2), 64'(15'b011111_01011010_1));
      chk("post_reset_done", 64'(done_cnt), 64'd1);

      wait_idle();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire
